// File: rtl/counter_dispatcher_pkg.sv
// Shared types and defaults for the counter dispatcher: slot FSM states and the
// round-robin pointer advance helper.
package sched_pkg;

  localparam int unsigned N_CNT_DEF  = 3;
  localparam int unsigned NUM_W_DEF  = 4;
  localparam int unsigned TIME_W_DEF = 4;

  typedef enum logic [0:0] {
    S_IDLE,
    S_SERVE
  } slot_state_e;

  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/counter_dispatcher_if.sv
// FIFO-head handshake between the customer FIFO (master) and the dispatcher (slave).
interface counter_dispatcher_if
  import sched_pkg::*;
#(
  parameter int unsigned NUM_W  = NUM_W_DEF,
  parameter int unsigned TIME_W = TIME_W_DEF
) ();

  logic              head_valid;
  logic [NUM_W-1:0]  head_num;
  logic [TIME_W-1:0] head_time;
  logic              head_pop;

  modport master (
    output head_valid,
    output head_num,
    output head_time,
    input  head_pop
  );

  modport slave (
    input  head_valid,
    input  head_num,
    input  head_time,
    output head_pop
  );

endinterface

// File: rtl/counter_dispatcher_slot.sv
// One service counter: loads a customer, counts its service time down and pulses
// done on the edge it returns to idle.
module counter_slot
  import sched_pkg::*;
#(
  parameter int unsigned NUM_W  = NUM_W_DEF,
  parameter int unsigned TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [NUM_W-1:0]  load_num,
  input  logic [TIME_W-1:0] load_time,
  output logic              busy,
  output logic [NUM_W-1:0]  num,
  output logic [TIME_W-1:0] rem,
  output logic              done
);

  slot_state_e       state_q, state_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_SERVE;
          num_d   = load_num;
          // A zero service time still occupies the counter for one cycle.
          rem_d   = (load_time == '0) ? TIME_W'(1) : load_time;
        end
      end
      S_SERVE: begin
        if (rem_q == TIME_W'(1)) begin
          state_d = S_IDLE;
          num_d   = '0;
          rem_d   = '0;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - TIME_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset is active-high here; aborted customers never raise done.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_SERVE);
  assign num  = num_q;
  assign rem  = rem_q;
  assign done = done_q;

endmodule

// File: rtl/counter_dispatcher.sv
// Pops the customer FIFO head into a free service counter, one grant per cycle.
// Round-robin by default; COUNTER_DISPATCHER_FIXED_PRIO_EN selects lowest-index-first.
module counter_dispatcher
  import sched_pkg::*;
#(
  parameter int unsigned N_CNT  = N_CNT_DEF,
  parameter int unsigned NUM_W  = NUM_W_DEF,
  parameter int unsigned TIME_W = TIME_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  counter_dispatcher_if.slave     head,
  output logic [N_CNT*NUM_W-1:0]  cnt_num,
  output logic [N_CNT*TIME_W-1:0] cnt_rem,
  output logic [N_CNT-1:0]        cnt_busy,
  output logic [N_CNT-1:0]        done_pulse,
  output logic [7:0]              served_cnt
);

  localparam int unsigned PtrW = $clog2(N_CNT);

  logic [N_CNT-1:0] free;
  logic [PtrW-1:0]  gnt_idx;
  logic [PtrW-1:0]  cand;
  logic             found;
  logic             head_pop;
  logic [7:0]       served_q, served_d;

  // Only slots whose registered busy is low are free, so a release never
  // shares an edge with a new grant.
  assign free     = ~cnt_busy;
  assign head_pop = !rst_n && head.head_valid && (|free);
  assign head.head_pop = head_pop;

`ifndef COUNTER_DISPATCHER_FIXED_PRIO_EN
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_CNT; i++) begin
`ifdef COUNTER_DISPATCHER_FIXED_PRIO_EN
      cand = PtrW'(i);
`else
      cand = PtrW'((32'(rr_ptr_q) + i) % N_CNT);
`endif
      if (!found && free[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

`ifndef COUNTER_DISPATCHER_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (head_pop) begin
      rr_ptr_d = PtrW'(next_rr(32'(gnt_idx), N_CNT));
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_comb begin
    served_d = served_q;
    if (head_pop && (served_q != 8'hff)) begin
      served_d = served_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      served_q <= '0;
    end else begin
      served_q <= served_d;
    end
  end

  assign served_cnt = served_q;

  for (genvar i = 0; i < N_CNT; i++) begin : g_slot
    logic              s_busy;
    logic [NUM_W-1:0]  s_num;
    logic [TIME_W-1:0] s_rem;
    logic              s_done;

    counter_slot #(
      .NUM_W (NUM_W),
      .TIME_W(TIME_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (head_pop && (gnt_idx == PtrW'(i))),
      .load_num (head.head_num),
      .load_time(head.head_time),
      .busy     (s_busy),
      .num      (s_num),
      .rem      (s_rem),
      .done     (s_done)
    );

    assign cnt_busy[i]                 = s_busy;
    assign done_pulse[i]               = s_done;
    assign cnt_num[i*NUM_W +: NUM_W]   = s_num;
    assign cnt_rem[i*TIME_W +: TIME_W] = s_rem;
  end

endmodule

// File: tb/tb_counter_dispatcher.sv
// Directed bench for counter_dispatcher with three 4-bit counters; expectations
// follow the COUNTER_DISPATCHER_FIXED_PRIO_EN setting.
module tb_counter_dispatcher;

  logic        clk;
  logic        rst_n;
  logic [11:0] cnt_num;
  logic [11:0] cnt_rem;
  logic [2:0]  cnt_busy;
  logic [2:0]  done_pulse;
  logic [7:0]  served_cnt;

  int checks;
  int errors;
  int pops;

  counter_dispatcher_if #(.NUM_W(4), .TIME_W(4)) head_if ();

  counter_dispatcher #(
    .N_CNT (3),
    .NUM_W (4),
    .TIME_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .head      (head_if),
    .cnt_num   (cnt_num),
    .cnt_rem   (cnt_rem),
    .cnt_busy  (cnt_busy),
    .done_pulse(done_pulse),
    .served_cnt(served_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [3:0] n, input logic [3:0] t);
    head_if.head_valid = v;
    head_if.head_num   = n;
    head_if.head_time  = t;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    drive(1'b1, 4'd5, 4'd3);
    tick();
    tick();

    // 1: reset state, then first grant into slot0
    chk("rst_pop", 32'(head_if.head_pop), 0);
    chk("rst_busy", 32'(cnt_busy), 0);
    chk("rst_num", 32'(cnt_num), 0);
    chk("rst_rem", 32'(cnt_rem), 0);
    chk("rst_done", 32'(done_pulse), 0);
    chk("rst_served", 32'(served_cnt), 0);
    rst_n = 1'b0;
    #1;
    chk("t1_pop", 32'(head_if.head_pop), 1);
    tick();
    chk("t1_busy", 32'(cnt_busy), 32'b001);
    chk("t1_num", 32'(cnt_num), 32'h005);
    chk("t1_rem", 32'(cnt_rem), 32'h003);
    chk("t1_served", 32'(served_cnt), 1);
    drive(1'b0, 4'd0, 4'd0);
    tick();
    chk("t1_rem2", 32'(cnt_rem), 32'h002);
    tick();
    tick();
    chk("t1_done", 32'(done_pulse), 32'b001);
    chk("t1_idle", 32'(cnt_busy), 0);
    tick();
    chk("t1_done_clr", 32'(done_pulse), 0);

    // 2: fill all three counters, fourth head waits
    do_reset();
    drive(1'b1, 4'd1, 4'd8);
    chk("t2_pop1", 32'(head_if.head_pop), 1);
    tick();
    chk("t2_num1", 32'(cnt_num), 32'h001);
    chk("t2_rem1", 32'(cnt_rem), 32'h008);
    drive(1'b1, 4'd2, 4'd8);
    tick();
    chk("t2_num2", 32'(cnt_num), 32'h021);
    chk("t2_rem2", 32'(cnt_rem), 32'h087);
    drive(1'b1, 4'd3, 4'd8);
    tick();
    chk("t2_num3", 32'(cnt_num), 32'h321);
    chk("t2_rem3", 32'(cnt_rem), 32'h876);
    drive(1'b1, 4'd4, 4'd1);
    chk("t2_full_pop", 32'(head_if.head_pop), 0);
    chk("t2_full_busy", 32'(cnt_busy), 32'b111);
    for (int k = 0; k < 5; k++) tick();
    chk("t2_wait_rem", 32'(cnt_rem), 32'h321);
    chk("t2_wait_pop", 32'(head_if.head_pop), 0);
    tick();
    chk("t2_s0_done", 32'(done_pulse), 32'b001);
    chk("t2_s0_free", 32'(cnt_busy), 32'b110);
    chk("t2_rem_rel", 32'(cnt_rem), 32'h210);
    chk("t2_pop4", 32'(head_if.head_pop), 1);
    tick();
    chk("t2_num4", 32'(cnt_num), 32'h304);
    chk("t2_rem4", 32'(cnt_rem), 32'h101);
    chk("t2_s1_done", 32'(done_pulse), 32'b010);
    chk("t2_served", 32'(served_cnt), 4);
    drive(1'b0, 4'd0, 4'd0);
    tick();
    chk("t2_done_s02", 32'(done_pulse), 32'b101);
    chk("t2_all_idle", 32'(cnt_busy), 0);

    // 3: zero service time runs exactly one cycle
    drive(1'b1, 4'd7, 4'd0);
    tick();
`ifdef COUNTER_DISPATCHER_FIXED_PRIO_EN
    chk("t3_busy", 32'(cnt_busy), 32'b001);
    chk("t3_num", 32'(cnt_num), 32'h007);
    chk("t3_rem", 32'(cnt_rem), 32'h001);
    drive(1'b0, 4'd0, 4'd0);
    tick();
    chk("t3_done", 32'(done_pulse), 32'b001);
`else
    chk("t3_busy", 32'(cnt_busy), 32'b010);
    chk("t3_num", 32'(cnt_num), 32'h070);
    chk("t3_rem", 32'(cnt_rem), 32'h010);
    drive(1'b0, 4'd0, 4'd0);
    tick();
    chk("t3_done", 32'(done_pulse), 32'b010);
`endif
    chk("t3_idle", 32'(cnt_busy), 0);
    tick();
    chk("t3_done_clr", 32'(done_pulse), 0);

    // 4: slot choice after slot0 has finished
    do_reset();
    drive(1'b1, 4'd1, 4'd2);
    tick();
    chk("t4_rem_a", 32'(cnt_rem), 32'h002);
    drive(1'b0, 4'd0, 4'd0);
    tick();
    tick();
    chk("t4_done", 32'(done_pulse), 32'b001);
    drive(1'b1, 4'd2, 4'd2);
    tick();
`ifdef COUNTER_DISPATCHER_FIXED_PRIO_EN
    chk("t4_busy", 32'(cnt_busy), 32'b001);
    chk("t4_num", 32'(cnt_num), 32'h002);
`else
    chk("t4_busy", 32'(cnt_busy), 32'b010);
    chk("t4_num", 32'(cnt_num), 32'h020);
`endif
    drive(1'b0, 4'd0, 4'd0);

    // 5: reset while all three serve with rem=5
    do_reset();
    drive(1'b1, 4'd1, 4'd7);
    tick();
    drive(1'b1, 4'd2, 4'd6);
    tick();
    drive(1'b1, 4'd3, 4'd5);
    tick();
    chk("t5_rem", 32'(cnt_rem), 32'h555);
    chk("t5_busy", 32'(cnt_busy), 32'b111);
    drive(1'b1, 4'd9, 4'd9);
    rst_n = 1'b1;
    #1;
    chk("t5_abort_busy", 32'(cnt_busy), 0);
    chk("t5_abort_rem", 32'(cnt_rem), 0);
    chk("t5_abort_num", 32'(cnt_num), 0);
    chk("t5_abort_pop", 32'(head_if.head_pop), 0);
    chk("t5_served", 32'(served_cnt), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_no_done_rst", 32'(done_pulse), 0);
    end
    drive(1'b0, 4'd0, 4'd0);
    rst_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_no_done_run", 32'(done_pulse | cnt_busy), 0);
    end

    // 6: served_cnt saturates while dispatch continues
    do_reset();
    pops = 0;
    head_if.head_valid = 1'b1;
    head_if.head_time  = 4'd0;
    for (int k = 0; k < 260; k++) begin
      head_if.head_num = 4'(k);
      #1;
      if (head_if.head_pop) pops++;
      tick();
    end
    chk("t6_pops", 32'(pops), 260);
    chk("t6_served_sat", 32'(served_cnt), 255);
    #1;
    chk("t6_pop_after_sat", 32'(head_if.head_pop), 1);
    head_if.head_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_dispatcher.md
Name: counter_dispatcher

Overview:
- Scheduler between the customer FIFO and the three service counters of the queue system.
- Pops the FIFO head whenever a counter is free and assigns it by round-robin.
- Runs a per-counter service countdown and reports each counter's number, remaining time, busy flag and completion pulse to the display/debug logic.

Parameters:
N_CNT, 3, number of service counters (2..8)
NUM_W, 4, customer number width
TIME_W, 4, service time width (cycles)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-high
head_valid  in  1  FIFO non-empty; head_num/head_time valid
head_num  in  NUM_W  customer number at FIFO head
head_time  in  TIME_W  requested service cycles at FIFO head
head_pop  out  1  combinational; FIFO pops head at this clock edge
cnt_num  out  N_CNT*NUM_W  number served per counter; slot i at [i*NUM_W +: NUM_W]; 0 when idle
cnt_rem  out  N_CNT*TIME_W  remaining cycles per counter; 0 when idle
cnt_busy  out  N_CNT  registered busy flag per counter
done_pulse  out  N_CNT  one-cycle pulse when a counter finishes
served_cnt  out  8  total customers dispatched, saturating

Behaviour:
- Reset (rst_n=1, asynchronous): all slots S_IDLE; cnt_num, cnt_rem, cnt_busy, done_pulse = 0; served_cnt = 0; rr_ptr = 0. head_pop = 0 while in reset.
- Per-slot FSM:
  - S_IDLE: busy=0, num=0, rem=0.
  - Grant: S_IDLE -> S_SERVE. Load num=head_num, rem=max(head_time,1); head_time=0 is served as 1 cycle.
  - S_SERVE: rem decrements by 1 each cycle.
  - At the edge where rem==1: rem->0, num->0, state->S_IDLE, done_pulse[i]=1 for exactly that following cycle.
- Free slot = registered cnt_busy[i]==0.
- head_pop = head_valid AND at least one free slot.
- At most one grant per cycle.
- Grant selection: first free slot searching rr_ptr, rr_ptr+1, ... mod N_CNT. On a grant, rr_ptr <= (granted+1) mod N_CNT; otherwise rr_ptr holds.
- Latency: head_pop asserts in the same cycle as head_valid when a slot is free. The slot shows busy/num/rem on the next edge.
- Release and grant in the same cycle: a slot finishing at edge k is not free before edge k. It can be granted at edge k+1 at the earliest, giving one idle cycle. No same-edge reuse.
- head_valid low: no grant, rr_ptr holds; counters keep counting.
- All slots busy: head_pop=0; head_num/head_time ignored and may change.
- served_cnt increments on each grant; holds at 255.
- Reset mid-service: all slots abort immediately to S_IDLE. No done_pulse is generated for aborted customers.

Optional Feature:
- Macro COUNTER_DISPATCHER_FIXED_PRIO_EN.
- Defined: grant goes to the lowest-index free slot; rr_ptr is removed.
- Undefined (default): round-robin as above.
- Both modes share all other timing.

Decomposition:
- Package sched_pkg:
  - localparams N_CNT_DEF=3, NUM_W_DEF=4, TIME_W_DEF=4.
  - slot state typedef {S_IDLE, S_SERVE}.
  - function next_rr(ptr, n).
- Sub-module counter_slot, instantiated N_CNT times:
  - inputs: clk, rst_n, load, load_num, load_time.
  - outputs: busy, num, rem, done.
- Top of the block holds the grant/rr_ptr logic and served_cnt.

Test Plan:
1. Reset asserted mid-run -> all outputs 0, head_pop=0; after release with head_valid=1 (num 5, time 3) -> slot0 num=5, rem=3 next edge.
2. Heads (1,8),(2,8),(3,8) back-to-back, then (4,1) -> pops on 3 consecutive cycles into slots 0,1,2, rem=8 each. Head 4 waits with head_pop=0 until slot0 done_pulse, then pops one cycle later into slot0 (rr_ptr=0).
3. head_time=0, num 7 -> slot busy exactly 1 cycle with rem=1; done_pulse next cycle.
4. One customer (1,2) to slot0, let finish, then (2,2) -> default build grants slot1. With COUNTER_DISPATCHER_FIXED_PRIO_EN it grants slot0.
5. Reset pulse while all three slots serve with rem=5 -> immediate idle, no done_pulse, served_cnt=0.
6. 260 single-cycle customers streamed -> served_cnt stops at 255, dispatching continues.
